// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: load-use, EX-resolved jumps, and data-memory waits with timeout.
// Stall/flush outputs are combinational (0 cycles) from state+inputs; bus_err and stall_cnt are registered.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic             EX_rmem,
    input  logic             EX_wen,
    input  logic [4:0]       EX_rd_addr,
    input  logic             EX_jump,
    input  logic             MEM_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_bus_err;

    logic w_mem_stall;
    logic w_timeout;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    always_comb begin
        w_mem_stall = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: w_mem_stall = MEM_req & ~mem_ready;
            WAIT: begin
                w_mem_stall = ~mem_ready & (r_wait_cnt < LAST);
                w_timeout   = ~mem_ready & (r_wait_cnt == LAST);
            end
            default: w_mem_stall = 1'b0;
        endcase
    end

    assign w_rs1_hit  = ID_rs1_used & (ID_rs1_addr == EX_rd_addr);
    assign w_rs2_hit  = ID_rs2_used & (ID_rs2_addr == EX_rd_addr);
    assign w_load_use = EX_rmem & EX_wen & (EX_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);

    // Priority: memory stall, then jump flush, then load-use bubble; all gated off during reset.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        if (rstn) begin
            if (w_mem_stall) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else begin
                flush_mem_wb = w_timeout;
                if (EX_jump) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (w_load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_mem_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (MEM_req && !mem_ready) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ready || w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign bus_err   = r_bus_err;

endmodule
